// File: rtl/mips_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Tracks post-EX writers, sequences load-use stalls, flushes and counters.
module mips_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 16,
  parameter int FSEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              br_taken,
  input  logic              clear_cnt,
  output logic              stall_if_id,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [FSEL_W-1:0] fwd_a,
  output logic [FSEL_W-1:0] fwd_b,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam logic RUN     = 1'b0;
  localparam logic LDSTALL = 1'b1;

  logic                 state;
  logic [1:0]           cnt;
  logic                 bubble_q;
  logic [FWD_DEPTH-1:0] t_valid;
  logic [FWD_DEPTH-1:0] t_wr;
  logic [FWD_DEPTH-1:0] t_load;
  logic [REG_AW-1:0]    t_rd [FWD_DEPTH];
  logic                 hazard;
  logic                 stall_raw;

  assign hazard = ex_memread & ex_regwrite & (ex_rd != '0)
                & ((id_use_rs & (id_rs == ex_rd))
                 | (id_use_rt & (id_rt == ex_rd)));

  assign stall_raw    = (state == LDSTALL) | hazard;
  // A taken branch squashes whatever the stall was protecting.
  assign stall_if_id  = reset & stall_raw & ~br_taken;
  assign bubble_id_ex = stall_if_id;
  assign flush_id_ex  = reset & br_taken;
  assign flush_if_id  = reset & (br_taken | (id_jump & ~stall_if_id));

  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    // Walk far-to-near so the nearest qualifying writer wins.
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (t_valid[k-1] && t_wr[k-1] && (t_rd[k-1] != '0)
          && !(t_load[k-1] && (k <= LOAD_LAT))) begin
        if (t_rd[k-1] == ex_rs) fwd_a = FSEL_W'(k);
        if (t_rd[k-1] == ex_rt) fwd_b = FSEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_valid <= '0;
      t_wr    <= '0;
      t_load  <= '0;
      for (int i = 0; i < FWD_DEPTH; i++) t_rd[i] <= '0;
    end else begin
      t_valid[0] <= ~br_taken & ~bubble_q;
      t_wr[0]    <= ex_regwrite;
      t_load[0]  <= ex_memread;
      t_rd[0]    <= ex_rd;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        t_valid[i] <= t_valid[i-1];
        t_wr[i]    <= t_wr[i-1];
        t_load[i]  <= t_load[i-1];
        t_rd[i]    <= t_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      cnt      <= '0;
      bubble_q <= 1'b0;
    end else begin
      bubble_q <= bubble_id_ex;
      if (br_taken) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        case (state)
          RUN: begin
            if (hazard && (LOAD_LAT > 1)) begin
              state <= LDSTALL;
              cnt   <= 2'(LOAD_LAT - 1);
            end
          end
          LDSTALL: begin
            if (cnt == 2'd1) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 2'd1;
            end
          end
          default: begin
            state <= RUN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (clear_cnt) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_if_id && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (br_taken && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Directed bench for mips_hazard_unit across three parameter sets.
// d0: defaults, d3: LOAD_LAT=3, d4: CNT_W=4 with LOAD_LAT=3.
module tb_mips_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd;
  logic       id_use_rs, id_use_rt, id_jump;
  logic       ex_regwrite, ex_memread, br_taken, clear_cnt;

  logic        s0, b0, fi0, fe0;
  logic [1:0]  fa0, fb0;
  logic [15:0] sc0, fv0;
  logic        s3, b3, fi3, fe3;
  logic [1:0]  fa3, fb3;
  logic [15:0] sc3, fv3;
  logic        s4, b4, fi4, fe4;
  logic [1:0]  fa4, fb4;
  logic [3:0]  sc4, fv4;

  int checks = 0;
  int fails  = 0;

  mips_hazard_unit d0 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .br_taken(br_taken), .clear_cnt(clear_cnt),
    .stall_if_id(s0), .bubble_id_ex(b0),
    .flush_if_id(fi0), .flush_id_ex(fe0),
    .fwd_a(fa0), .fwd_b(fb0),
    .stall_cycles(sc0), .flush_events(fv0)
  );

  mips_hazard_unit #(.LOAD_LAT(3)) d3 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .br_taken(br_taken), .clear_cnt(clear_cnt),
    .stall_if_id(s3), .bubble_id_ex(b3),
    .flush_if_id(fi3), .flush_id_ex(fe3),
    .fwd_a(fa3), .fwd_b(fb3),
    .stall_cycles(sc3), .flush_events(fv3)
  );

  mips_hazard_unit #(.LOAD_LAT(3), .CNT_W(4)) d4 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_jump(id_jump),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .br_taken(br_taken), .clear_cnt(clear_cnt),
    .stall_if_id(s4), .bubble_id_ex(b4),
    .flush_if_id(fi4), .flush_id_ex(fe4),
    .fwd_a(fa4), .fwd_b(fb4),
    .stall_cycles(sc4), .flush_events(fv4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; id_jump = 0;
    ex_regwrite = 0; ex_memread = 0; br_taken = 0; clear_cnt = 0;
  endtask

  task automatic settle();
    idle();
    clear_cnt = 1;
    tick();
    clear_cnt = 0;
    tick();
    tick();
  endtask

  // EX holds lw r2, ID holds an instruction reading r2 as rs.
  task automatic drive_load_use();
    ex_rd = 5'd2; ex_regwrite = 1; ex_memread = 1;
    id_rs = 5'd2; id_use_rs = 1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    #12;
    checks++;
    if ({s0, b0, fi0, fe0} !== 4'b0) begin
      $display("FAIL reset_ctrl: got %b want 0000", {s0, b0, fi0, fe0});
      fails++;
    end
    checks++;
    if ({fa0, fb0} !== 4'b0) begin
      $display("FAIL reset_fwd: got %b want 0000", {fa0, fb0});
      fails++;
    end
    checks++;
    if (sc0 !== 16'd0 || fv0 !== 16'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", sc0, fv0);
      fails++;
    end
    checks++;
    if (sc4 !== 4'd0 || s3 !== 1'b0) begin
      $display("FAIL reset_other: got %0d/%b want 0/0", sc4, s3);
      fails++;
    end
    #3;
    reset = 1;
    tick();
  endtask

  task automatic test_load_use();
    settle();
    drive_load_use();
    #2;
    checks++;
    if (s0 !== 1'b1 || b0 !== 1'b1) begin
      $display("FAIL lu_stall: got %b%b want 11", s0, b0);
      fails++;
    end
    tick();
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    ex_rs = 5'd2;
    #2;
    checks++;
    if (s0 !== 1'b0 || b0 !== 1'b0) begin
      $display("FAIL lu_release: got %b%b want 00", s0, b0);
      fails++;
    end
    checks++;
    if (fa0 !== 2'd0) begin
      $display("FAIL lu_load_k1: got %0d want 0", fa0);
      fails++;
    end
    checks++;
    if (sc0 !== 16'd1) begin
      $display("FAIL lu_count: got %0d want 1", sc0);
      fails++;
    end
    tick();
    id_rs = '0; id_use_rs = 0;
    ex_rs = 5'd2; ex_rd = 5'd3; ex_regwrite = 1;
    #2;
    checks++;
    if (fa0 !== 2'd2) begin
      $display("FAIL lu_fwd: got %0d want 2", fa0);
      fails++;
    end
    checks++;
    if (s0 !== 1'b0 || sc0 !== 16'd1) begin
      $display("FAIL lu_after: got %b/%0d want 0/1", s0, sc0);
      fails++;
    end
  endtask

  task automatic test_alu_back_to_back();
    settle();
    ex_rd = 5'd1; ex_regwrite = 1;
    tick();
    ex_rs = 5'd1; ex_rd = 5'd4;
    #2;
    checks++;
    if (fa0 !== 2'd1 || s0 !== 1'b0) begin
      $display("FAIL alu_k1: got %0d/%b want 1/0", fa0, s0);
      fails++;
    end
    tick();
    ex_rs = 5'd1; ex_rt = 5'd4; ex_rd = 5'd6;
    #2;
    checks++;
    if (fa0 !== 2'd2) begin
      $display("FAIL alu_k2: got %0d want 2", fa0);
      fails++;
    end
    checks++;
    if (fb0 !== 2'd1) begin
      $display("FAIL alu_fwd_b: got %0d want 1", fb0);
      fails++;
    end
  endtask

  task automatic test_reg_zero_double();
    settle();
    ex_rd = 5'd0; ex_regwrite = 1;
    tick();
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd5;
    #2;
    checks++;
    if (fa0 !== 2'd0 || fb0 !== 2'd0) begin
      $display("FAIL r0_fwd: got %0d/%0d want 0/0", fa0, fb0);
      fails++;
    end
    tick();
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd5;
    tick();
    ex_rt = 5'd5; ex_rd = 5'd9;
    #2;
    checks++;
    if (fb0 !== 2'd1) begin
      $display("FAIL double_match: got %0d want 1", fb0);
      fails++;
    end
  endtask

  task automatic test_branch_squash();
    settle();
    ex_rd = 5'd7; ex_regwrite = 1; br_taken = 1;
    #2;
    checks++;
    if (fi0 !== 1'b1 || fe0 !== 1'b1) begin
      $display("FAIL br_flush: got %b%b want 11", fi0, fe0);
      fails++;
    end
    tick();
    br_taken = 0; ex_rd = 5'd8; ex_rs = 5'd7;
    #2;
    checks++;
    if (fa0 !== 2'd0) begin
      $display("FAIL br_squash: got %0d want 0", fa0);
      fails++;
    end
    checks++;
    if (fv0 !== 16'd1 || fi0 !== 1'b0) begin
      $display("FAIL br_count: got %0d/%b want 1/0", fv0, fi0);
      fails++;
    end
  endtask

  task automatic test_flush_during_stall();
    settle();
    drive_load_use();
    #2;
    checks++;
    if (s3 !== 1'b1 || b3 !== 1'b1) begin
      $display("FAIL fds_first: got %b%b want 11", s3, b3);
      fails++;
    end
    tick();
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    #2;
    checks++;
    if (s3 !== 1'b1) begin
      $display("FAIL fds_ldstall: got %b want 1", s3);
      fails++;
    end
    br_taken = 1;
    #1;
    checks++;
    if ({s3, b3, fi3, fe3} !== 4'b0011) begin
      $display("FAIL fds_flush: got %b want 0011", {s3, b3, fi3, fe3});
      fails++;
    end
    tick();
    idle();
    #2;
    checks++;
    if (s3 !== 1'b0 || fi3 !== 1'b0) begin
      $display("FAIL fds_run: got %b%b want 00", s3, fi3);
      fails++;
    end
    checks++;
    if (fv3 !== 16'd1 || sc3 !== 16'd1) begin
      $display("FAIL fds_cnt: got %0d/%0d want 1/1", fv3, sc3);
      fails++;
    end
  endtask

  task automatic test_jump_vs_stall();
    settle();
    drive_load_use();
    id_jump = 1;
    #2;
    checks++;
    if (s0 !== 1'b1 || fi0 !== 1'b0) begin
      $display("FAIL jmp_hold: got %b%b want 10", s0, fi0);
      fails++;
    end
    tick();
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    #2;
    checks++;
    if (s0 !== 1'b0 || fi0 !== 1'b1 || fe0 !== 1'b0) begin
      $display("FAIL jmp_release: got %b%b%b want 010", s0, fi0, fe0);
      fails++;
    end
  endtask

  task automatic test_saturation_reset();
    settle();
    drive_load_use();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (sc4 !== 4'd15) begin
      $display("FAIL sat_15: got %0d want 15", sc4);
      fails++;
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (sc4 !== 4'd15) begin
      $display("FAIL sat_hold: got %0d want 15", sc4);
      fails++;
    end
    checks++;
    if (sc0 !== 16'd20) begin
      $display("FAIL sat_wide: got %0d want 20", sc0);
      fails++;
    end
    clear_cnt = 1;
    tick();
    clear_cnt = 0;
    #2;
    checks++;
    if (sc4 !== 4'd0) begin
      $display("FAIL clear: got %0d want 0", sc4);
      fails++;
    end
    tick();
    idle();
    #2;
    checks++;
    if (s4 !== 1'b1 || sc4 !== 4'd1) begin
      $display("FAIL ldstall_mid: got %b/%0d want 1/1", s4, sc4);
      fails++;
    end
    reset = 0;
    #1;
    checks++;
    if ({s4, b4, fi4, fe4, fa4, fb4} !== 8'b0) begin
      $display("FAIL async_ctrl: got %b want 0",
               {s4, b4, fi4, fe4, fa4, fb4});
      fails++;
    end
    checks++;
    if (sc4 !== 4'd0 || fv4 !== 4'd0) begin
      $display("FAIL async_cnt: got %0d/%0d want 0/0", sc4, fv4);
      fails++;
    end
    #2;
    reset = 1;
    tick();
    #2;
    checks++;
    if (s4 !== 1'b0) begin
      $display("FAIL post_reset: got %b want 0", s4);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_back_to_back();
    test_reg_zero_double();
    test_branch_squash();
    test_flush_during_stall();
    test_jump_vs_stall();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
